// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM state encoding and master index constants.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_pick2.sv
// arb_pick2: combinational two-way winner selection (round-robin against the last grant).
// Build macro ARB_FIXED_PRIO_EN switches the tie rule to fixed priority for master 0.
module arb_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // A tie goes to the master that did not win last time, unless fixed priority is built in
  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b10) begin
      winner = M1;
    end else if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = M0;
`else
      winner = ~last;
`endif
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises two masters onto one synchronous 1-cycle-latency RAM.
// Build macro ARB_FIXED_PRIO_EN selects fixed priority (master 0) instead of round-robin.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          we_d;
  logic [1:0]    gnt_d;
  logic [1:0]    rvalid_d;
  logic [DW-1:0] rdata0_d, rdata1_d;
  logic          busy_d;
  logic          pick_valid;
  logic          pick_winner;

  arb_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    we_d     = 1'b0;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = pick_winner;
`endif
          gnt_d[pick_winner] = 1'b1;
          state_d = ACCESS;
          if (pick_winner == M1) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            we_d    = m1_we;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            we_d    = m0_we;
          end
        end
      end
      // mem_we still reflects the accepted command, so it tells write from read here
      ACCESS: state_d = mem_we ? IDLE : RDATA;
      RDATA: begin
        rvalid_d[owner_q] = 1'b1;
        if (owner_q == M1) rdata1_d = mem_rdata;
        else               rdata0_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      last_q    <= M1;
      owner_q   <= M0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      m0_gnt    <= gnt_d[0];
      m1_gnt    <= gnt_d[1];
      m0_rvalid <= rvalid_d[0];
      m1_rvalid <= rvalid_d[1];
      m0_rdata  <= rdata0_d;
      m1_rdata  <= rdata1_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic and resets,
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    req_v;
  logic          cmd_we    [2];
  logic [AW-1:0] cmd_addr  [2];
  logic [DW-1:0] cmd_wdata [2];
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          ram_init;

  always #5 Clock = ~Clock;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .m0_req    (req_v[0]),
    .m0_we     (cmd_we[0]),
    .m0_addr   (cmd_addr[0]),
    .m0_wdata  (cmd_wdata[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (req_v[1]),
    .m1_we     (cmd_we[1]),
    .m1_addr   (cmd_addr[1]),
    .m1_wdata  (cmd_wdata[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Environment RAM: synchronous, one cycle read latency, 256 words visible
  logic [DW-1:0] ram [0:255];
  always @(posedge Clock) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  int            tests = 0;
  int            failures = 0;
  int            cyc = 0;
  int            grants [2];
  logic [DW-1:0] ref_mem [0:255];
  logic          idle_prev;
  logic          last_w;
  logic          pend;
  logic          pend_m;
  int            pend_cyc;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] exp_rd [2];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          exp_we;
  logic          exp_busy;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
    cmd_we[k]    = we;
    cmd_addr[k]  = addr;
    cmd_wdata[k] = wdata;
    req_v[k]     = 1'b1;
  endtask

  // One clock: predict what this cycle must show from the inputs sampled at its opening edge
  task automatic step();
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    logic       win;
    @(negedge Clock);
    cyc++;
    exp_gnt = 2'b00;
    exp_rv  = 2'b00;
    if (Reset) begin
      pend      = 1'b0;
      last_w    = 1'b1;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_we    = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_busy  = 1'b0;
    end else begin
      exp_we = 1'b0;
      if (pend && pend_cyc == cyc) begin
        exp_rv[pend_m]  = 1'b1;
        exp_rd[pend_m]  = pend_data;
        pend            = 1'b0;
      end
      if (idle_prev && req_v != 2'b00) begin
        if (req_v == 2'b11) win = FIXED ? 1'b0 : ~last_w;
        else                win = req_v[1];
        exp_gnt[win] = 1'b1;
        last_w       = win;
        exp_addr     = cmd_addr[win];
        exp_wdata    = cmd_wdata[win];
        exp_we       = cmd_we[win];
        if (cmd_we[win]) begin
          ref_mem[cmd_addr[win][7:0]] = cmd_wdata[win];
        end else begin
          pend      = 1'b1;
          pend_m    = win;
          pend_cyc  = cyc + 2;
          pend_data = ref_mem[cmd_addr[win][7:0]];
        end
      end
      exp_busy = (exp_gnt != 2'b00) || (pend && pend_cyc == cyc + 1);
    end
    idle_prev = ~exp_busy;
    check_output("gnt",       {30'd0, m1_gnt, m0_gnt},       {30'd0, exp_gnt});
    check_output("rvalid",    {30'd0, m1_rvalid, m0_rvalid}, {30'd0, exp_rv});
    check_output("mem_we",    {31'd0, mem_we},   {31'd0, exp_we});
    check_output("mem_addr",  {16'd0, mem_addr}, {16'd0, exp_addr});
    check_output("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
    check_output("busy",      {31'd0, busy},     {31'd0, exp_busy});
    check_output("m0_rdata",  {16'd0, m0_rdata}, {16'd0, exp_rd[0]});
    check_output("m1_rdata",  {16'd0, m1_rdata}, {16'd0, exp_rd[1]});
    if (m0_gnt) begin req_v[0] = 1'b0; grants[0]++; end
    if (m1_gnt) begin req_v[1] = 1'b0; grants[1]++; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    req_v     = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cmd_we[k] = 1'b0; cmd_addr[k] = '0; cmd_wdata[k] = '0; exp_rd[k] = '0; grants[k] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    idle_prev = 1'b1;
    last_w    = 1'b1;
    pend      = 1'b0;
    pend_m    = 1'b0;
    pend_cyc  = 0;
    pend_data = '0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_we    = 1'b0;
    exp_busy  = 1'b0;
    Reset     = 1'b1;
    ram_init  = 1'b1;
    step();
    ram_init = 1'b0;
    step();
    Reset = 1'b0;

    apply_stimulus(0, 1'b1, 16'h0010, 16'hBEEF);
    run(4);
    apply_stimulus(1, 1'b0, 16'h0010, 16'h0000);
    run(5);
    check_output("rd_beef", {16'd0, m1_rdata}, 32'h0000BEEF);

    apply_stimulus(0, 1'b1, 16'h0005, 16'h1234);
    run(3);
    apply_stimulus(1, 1'b0, 16'h0005, 16'h0000);
    run(5);
    check_output("wr_then_rd", {16'd0, m1_rdata}, 32'h00001234);

    // Both masters keep reading; each stops after three grants
    grants[0] = 0;
    grants[1] = 0;
    apply_stimulus(0, 1'b0, 16'(($urandom_range(0, 15))), 16'h0000);
    apply_stimulus(1, 1'b0, 16'(($urandom_range(0, 15))), 16'h0000);
    for (int i = 0; i < 24; i++) begin
      step();
      for (int k = 0; k < 2; k++)
        if (!req_v[k] && grants[k] < 3)
          apply_stimulus(k, 1'b0, 16'(($urandom_range(0, 15))), 16'h0000);
    end
    check_output("tie_m0_grants", grants[0], 32'd3);
    check_output("tie_m1_grants", grants[1], 32'd3);
    run(3);

    // Reset lands on the RDATA cycle of an m0 read
    apply_stimulus(0, 1'b0, 16'h0005, 16'h0000);
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    apply_stimulus(1, 1'b0, 16'h0005, 16'h0000);
    run(5);
    check_output("post_reset_rd", {16'd0, m1_rdata}, 32'h00001234);

    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 99) == 0);
      step();
      for (int k = 0; k < 2; k++)
        if (!req_v[k] && $urandom_range(0, 99) < 40)
          apply_stimulus(k, 1'($urandom_range(0, 1)), 16'(($urandom_range(0, 15))),
                         16'($urandom));
    end
    Reset = 1'b0;
    req_v = 2'b00;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
